// File: rtl/proc_ctrl_pkg.sv
// Shared definitions for the processor control unit: step encodings and opcodes.
package proc_ctrl_pkg;

  // Control step of the current instruction; the encoding is visible on Tstep.
  typedef enum logic [1:0] {
    T0 = 2'b00,
    T1 = 2'b01,
    T2 = 2'b10,
    T3 = 2'b11
  } state_t;

  // Opcodes implemented by the controller; 100..111 are decoded as illegal.
  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

endpackage

// File: rtl/proc_ctrl_dec3to8.sv
// 3-to-8 one-hot decoder with enable; selects one of R0..R7 from a register field.
module proc_ctrl_dec3to8 (
  input  logic [2:0] i_w,
  input  logic       i_en,
  output logic [7:0] o_y
);

  // Raise exactly one output bit when enabled, none otherwise.
  always_comb begin
    o_y = 8'h00;
    if (i_en) begin
      o_y[i_w] = 1'b1;
    end
  end

endmodule

// File: rtl/proc_ctrl.sv
// Multi-cycle control unit for a small bus-based processor (mv, mvi, add, sub).
// Control outputs are decoded combinationally from the step register, IR and Run.
module proc_ctrl (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Run,
  input  logic [8:0] IR,
  output logic       IRin,
  output logic [7:0] Rin,
  output logic [7:0] Rout,
  output logic       Ain,
  output logic       Gin,
  output logic       Gout,
  output logic       DINout,
  output logic       AddSub,
  output logic       Done,
  output logic       Illegal,
  output logic [1:0] Tstep
);

  import proc_ctrl_pkg::*;

  state_t     r_state;
  state_t     w_next;
  logic [2:0] w_op;
  logic [7:0] w_x_oh;
  logic [7:0] w_y_oh;

  assign w_op  = IR[8:6];
  assign Tstep = r_state;

  // Destination register field (X) to a one-hot select.
  proc_ctrl_dec3to8 u_dec_x (
    .i_w  (IR[5:3]),
    .i_en (1'b1),
    .o_y  (w_x_oh)
  );

  // Source register field (Y) to a one-hot select.
  proc_ctrl_dec3to8 u_dec_y (
    .i_w  (IR[2:0]),
    .i_en (1'b1),
    .o_y  (w_y_oh)
  );

  // Step register; reset abandons any instruction in flight and returns to T0.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= T0;
    end else begin
      r_state <= w_next;
    end
  end

  // Per-step control decode and next-step selection; everything forced low in reset.
  always_comb begin
    w_next  = r_state;
    IRin    = 1'b0;
    Rin     = 8'h00;
    Rout    = 8'h00;
    Ain     = 1'b0;
    Gin     = 1'b0;
    Gout    = 1'b0;
    DINout  = 1'b0;
    AddSub  = 1'b0;
    Done    = 1'b0;
    Illegal = 1'b0;
    case (r_state)
      T0: begin
        IRin   = Run;
        w_next = Run ? T1 : T0;
      end
      T1: begin
        case (w_op)
          OP_MV: begin
            Rout   = w_y_oh;
            Rin    = w_x_oh;
            Done   = 1'b1;
            w_next = T0;
          end
          OP_MVI: begin
            DINout = 1'b1;
            Rin    = w_x_oh;
            Done   = 1'b1;
            w_next = T0;
          end
          OP_ADD, OP_SUB: begin
            Rout   = w_x_oh;
            Ain    = 1'b1;
            w_next = T2;
          end
          default: begin
            // Unimplemented opcode: finish immediately without touching the datapath.
            Done    = 1'b1;
            Illegal = 1'b1;
            w_next  = T0;
          end
        endcase
      end
      T2: begin
        Rout   = w_y_oh;
        Gin    = 1'b1;
        AddSub = (w_op == OP_SUB);
        w_next = T3;
      end
      T3: begin
        Gout   = 1'b1;
        Rin    = w_x_oh;
        Done   = 1'b1;
        w_next = T0;
      end
      default: begin
        w_next = T0;
      end
    endcase
    if (!Resetn) begin
      IRin    = 1'b0;
      Rin     = 8'h00;
      Rout    = 8'h00;
      Ain     = 1'b0;
      Gin     = 1'b0;
      Gout    = 1'b0;
      DINout  = 1'b0;
      AddSub  = 1'b0;
      Done    = 1'b0;
      Illegal = 1'b0;
    end
  end

endmodule

// File: tb/tb_proc_ctrl.sv
// Randomized and directed bench for proc_ctrl against a queue-based instruction model.
module tb_proc_ctrl;

  typedef struct packed {
    logic [1:0] tstep;
    logic       irin;
    logic [7:0] rin;
    logic [7:0] rout;
    logic       ain;
    logic       gin;
    logic       gout;
    logic       dinout;
    logic       addsub;
    logic       done;
    logic       illegal;
  } vec_t;

  logic       Clock;
  logic       Resetn;
  logic       Run;
  logic [8:0] IR;
  logic       IRin;
  logic [7:0] Rin;
  logic [7:0] Rout;
  logic       Ain;
  logic       Gin;
  logic       Gout;
  logic       DINout;
  logic       AddSub;
  logic       Done;
  logic       Illegal;
  logic [1:0] Tstep;

  int   check_cnt;
  int   error_cnt;
  vec_t exp_q[$];
  vec_t got;

  proc_ctrl dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .Run     (Run),
    .IR      (IR),
    .IRin    (IRin),
    .Rin     (Rin),
    .Rout    (Rout),
    .Ain     (Ain),
    .Gin     (Gin),
    .Gout    (Gout),
    .DINout  (DINout),
    .AddSub  (AddSub),
    .Done    (Done),
    .Illegal (Illegal),
    .Tstep   (Tstep)
  );

  assign got = '{tstep: Tstep, irin: IRin, rin: Rin, rout: Rout, ain: Ain, gin: Gin,
                 gout: Gout, dinout: DINout, addsub: AddSub, done: Done, illegal: Illegal};

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      error_cnt++;
      $display("FAIL %s got=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected outputs of an idle T0 cycle.
  function automatic vec_t idle_vec(input logic run);
    vec_t v = '0;
    v.irin = run;
    return v;
  endfunction

  // Queue the per-cycle outputs an instruction produces after its T0 cycle.
  task automatic launch(input logic [8:0] ir);
    vec_t v;
    logic [7:0] xo;
    logic [7:0] yo;
    xo = 8'h01 << ir[5:3];
    yo = 8'h01 << ir[2:0];
    case (ir[8:6])
      3'd0: begin
        v = '0; v.tstep = 2'd1; v.rout = yo; v.rin = xo; v.done = 1'b1;
        exp_q.push_back(v);
      end
      3'd1: begin
        v = '0; v.tstep = 2'd1; v.dinout = 1'b1; v.rin = xo; v.done = 1'b1;
        exp_q.push_back(v);
      end
      3'd2, 3'd3: begin
        v = '0; v.tstep = 2'd1; v.rout = xo; v.ain = 1'b1;
        exp_q.push_back(v);
        v = '0; v.tstep = 2'd2; v.rout = yo; v.gin = 1'b1; v.addsub = (ir[8:6] == 3'd3);
        exp_q.push_back(v);
        v = '0; v.tstep = 2'd3; v.gout = 1'b1; v.rin = xo; v.done = 1'b1;
        exp_q.push_back(v);
      end
      default: begin
        v = '0; v.tstep = 2'd1; v.done = 1'b1; v.illegal = 1'b1;
        exp_q.push_back(v);
      end
    endcase
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic step(input logic run, input logic [8:0] ir, input string tag);
    vec_t e;
    @(posedge Clock);
    #1;
    Run = run;
    IR  = ir;
    #1;
    e = (exp_q.size() == 0) ? idle_vec(run) : exp_q[0];
    check(tag, 32'(got), 32'(e));
    check({tag, "_onebus"}, 32'($countones({Rout, Gout, DINout}) <= 1), 32'd1);
    $display("cyc %s run=%0b ir=%b tstep=%0d out=%h", tag, run, ir, Tstep, got);
    if (exp_q.size() == 0) begin
      if (run) launch(ir);
    end else begin
      exp_q.delete(0);
    end
  endtask

  initial begin
    logic [8:0] rir;
    logic       rrun;
    check_cnt = 0;
    error_cnt = 0;
    Resetn = 1'b0;
    Run    = 1'b1;
    IR     = 9'b001_000_000;
    #2;
    check("rst_hold", 32'(got), 32'd0);
    @(posedge Clock);
    #3;
    check("rst_edge", 32'(got), 32'd0);
    Run    = 1'b0;
    Resetn = 1'b1;

    for (int i = 0; i < 10; i++) step(1'b0, 9'b010_011_100, "idle");

    step(1'b1, 9'b001_000_000, "mvi_t0");
    step(1'b0, 9'b001_000_000, "mvi_t1");
    step(1'b0, 9'b001_000_000, "mvi_after");

    step(1'b1, 9'b011_001_010, "sub_t0");
    step(1'b1, 9'b011_001_010, "sub_t1");
    step(1'b1, 9'b011_001_010, "sub_t2");
    step(1'b0, 9'b011_001_010, "sub_t3");

    step(1'b1, 9'b000_101_011, "mv_t0");
    step(1'b1, 9'b000_101_011, "mv_t1");

    step(1'b1, 9'b111_000_000, "ill_t0");
    step(1'b0, 9'b111_000_000, "ill_t1");
    step(1'b0, 9'b111_000_000, "ill_after");

    step(1'b1, 9'b000_011_011, "mvsame_t0");
    step(1'b0, 9'b000_011_011, "mvsame_t1");

    // Reset pulse in the middle of the T2 cycle of an add.
    step(1'b1, 9'b010_100_110, "add_t0");
    step(1'b0, 9'b010_100_110, "add_t1");
    step(1'b0, 9'b010_100_110, "add_t2");
    #1;
    Resetn = 1'b0;
    Run    = 1'b1;
    #1;
    check("rst_mid", 32'(got), 32'd0);
    IR = 9'b001_111_000;
    #1;
    Resetn = 1'b1;
    #1;
    exp_q.delete();
    check("rst_rel", 32'(got), 32'(idle_vec(1'b1)));
    launch(IR);
    step(1'b0, 9'b001_111_000, "post_rst_t1");

    rir = 9'b0;
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0) rir = 9'($urandom);
      rrun = ($urandom_range(0, 3) != 0);
      step(rrun, rir, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
    $finish;
  end

endmodule
